trees_acc_sequencer: RTL and testbench

Command-driven front end for the tree-ensemble ping-pong accelerator: it turns a 64-bit input word stream into the accelerator's write-side strobes and returns the packed predictions as an output stream. It drives tree loads, feature loads, the `start`/`done` handshake and the prediction read port. It sits between the system DMA/stream fabric and the accelerator core, and is the only master of the accelerator's load and read ports.

---
 rtl/trees_acc_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_trees_acc_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trees_acc_sequencer.sv
// rtl/trees_acc_sequencer.sv - command sequencer for the tree-ensemble ping-pong accelerator
// Turns a 64-bit word stream into tree/feature writes and returns packed predictions.
module trees_acc_sequencer #(
  parameter int N_TREES          = 16,
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32,
  parameter int MAX_BURST        = 5000,
  localparam int TW = $clog2(N_TREES),
  localparam int NW = $clog2(N_NODE_AND_LEAFS),
  localparam int FW = $clog2(MAX_BURST * N_FEATURE / 2),
  localparam int LW = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [LW-1:0] cmd_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          out_last,
  output logic          cmd_done,
  output logic          cmd_err,
  output logic          busy,
  output logic          load_trees,
  output logic [TW-1:0] n_tree,
  output logic [NW-1:0] n_node,
  output logic [63:0]   tree_nodes,
  output logic          load_features,
  output logic [FW-1:0] feature_addr,
  output logic [63:0]   features2,
  output logic          start,
  output logic [LW-1:0] burst_len,
  input  logic          done,
  output logic [LW-1:0] prediction_addr,
  input  logic [63:0]   prediction
);

  typedef enum logic [2:0] {
    IDLE, LD_TREES, LD_FEAT, START, WAIT_DONE, RD_ADDR, RD_HOLD
  } state_t;

  localparam logic [TW-1:0] LAST_TREE = TW'(N_TREES - 1);
  localparam logic [NW-1:0] LAST_NODE = NW'(N_NODE_AND_LEAFS - 1);
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_BURST);

  state_t        state_q, state_d;
  logic [TW-1:0] tree_q;
  logic [NW-1:0] node_q;
  logic [31:0]   word_q;
  logic [31:0]   feat_words_q;
  logic [31:0]   last_idx_q;
  logic [31:0]   rd_idx_q;
  logic          len_ok;
  logic          last_tree_word;
  logic          last_feat_word;

  assign len_ok          = (cmd_len != '0) && (cmd_len <= MAX_LEN);
  assign last_tree_word  = (tree_q == LAST_TREE) && (node_q == LAST_NODE);
  assign last_feat_word  = (word_q == feat_words_q - 32'd1);
  assign cmd_ready       = (state_q == IDLE);
  assign in_ready        = (state_q == LD_TREES) || (state_q == LD_FEAT);
  assign busy            = (state_q != IDLE);
  assign prediction_addr = LW'(rd_idx_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_op)     state_d = LD_TREES;
          else if (len_ok) state_d = LD_FEAT;
        end
      end
      LD_TREES:  if (in_valid && last_tree_word) state_d = IDLE;
      LD_FEAT:   if (in_valid && last_feat_word) state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (done) state_d = RD_ADDR;
      RD_ADDR:   state_d = RD_HOLD;
      RD_HOLD:   if (out_ready) state_d = out_last ? IDLE : RD_ADDR;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tree_q        <= '0;
      node_q        <= '0;
      word_q        <= '0;
      feat_words_q  <= '0;
      last_idx_q    <= '0;
      rd_idx_q      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_err       <= 1'b0;
      load_trees    <= 1'b0;
      n_tree        <= '0;
      n_node        <= '0;
      tree_nodes    <= '0;
      load_features <= 1'b0;
      feature_addr  <= '0;
      features2     <= '0;
      start         <= 1'b0;
      burst_len     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_done      <= 1'b0;
      cmd_err       <= 1'b0;
      load_trees    <= 1'b0;
      load_features <= 1'b0;
      start         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            tree_q <= '0;
            node_q <= '0;
            word_q <= '0;
            if (cmd_op) begin
              if (cmd_len == '0) begin
                cmd_done <= 1'b1;
              end else if (!len_ok) begin
                cmd_err <= 1'b1;
              end else begin
                burst_len    <= cmd_len;
                feat_words_q <= 32'(cmd_len) * 32'(N_FEATURE / 2);
                last_idx_q   <= ((32'(cmd_len) + 32'd7) >> 3) - 32'd1;
              end
            end
          end
        end
        LD_TREES: begin
          if (in_valid) begin
            load_trees <= 1'b1;
            n_tree     <= tree_q;
            n_node     <= node_q;
            tree_nodes <= in_data;
            // node index wraps into the tree index: k/N and k%N without a divider
            if (node_q == LAST_NODE) begin
              node_q <= '0;
              tree_q <= tree_q + 1'b1;
            end else begin
              node_q <= node_q + 1'b1;
            end
            if (last_tree_word) cmd_done <= 1'b1;
          end
        end
        LD_FEAT: begin
          if (in_valid) begin
            load_features <= 1'b1;
            feature_addr  <= FW'(word_q);
            features2     <= in_data;
            word_q        <= word_q + 32'd1;
          end
        end
        START: start <= 1'b1;
        WAIT_DONE: if (done) rd_idx_q <= '0;
        RD_ADDR: begin
          out_data  <= prediction;
          out_valid <= 1'b1;
          out_last  <= (rd_idx_q == last_idx_q);
        end
        RD_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) cmd_done <= 1'b1;
            else          rd_idx_q <= rd_idx_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trees_acc_sequencer.sv
// tb/tb_trees_acc_sequencer.sv - self-checking bench for trees_acc_sequencer
module tb_trees_acc_sequencer;

  localparam int N_TREES = 16;
  localparam int N_NODE  = 256;
  localparam int N_FEAT  = 32;
  localparam int MAXB    = 5000;
  localparam int TW = 4, NW = 8, FW = 17, LW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic out_valid, out_ready = 1'b1, out_last;
  logic [63:0] out_data;
  logic cmd_done, cmd_err, busy;
  logic load_trees;
  logic [TW-1:0] n_tree;
  logic [NW-1:0] n_node;
  logic [63:0] tree_nodes;
  logic load_features;
  logic [FW-1:0] feature_addr;
  logic [63:0] features2;
  logic start;
  logic [LW-1:0] burst_len;
  logic done = 1'b0;
  logic [LW-1:0] prediction_addr;
  logic [63:0] prediction;

  trees_acc_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
    .load_trees(load_trees), .n_tree(n_tree), .n_node(n_node), .tree_nodes(tree_nodes),
    .load_features(load_features), .feature_addr(feature_addr), .features2(features2),
    .start(start), .burst_len(burst_len), .done(done),
    .prediction_addr(prediction_addr), .prediction(prediction)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] salt = 32'h1234_5678;
  bit rdy_rand = 1'b0;

  // prediction memory contents, a function of address and a per-command salt
  function automatic logic [63:0] pred_fn(input int a);
    return {salt ^ 32'(a), 32'(a) * 32'h9E37_79B1};
  endfunction

  always_comb prediction = pred_fn(int'(prediction_addr));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: counts of outstanding work plus the cycle each event is due
  int cyc = 0;
  int words_left = 0, k = 0;
  bit mode_feat = 1'b0, busy_m = 1'b0, stall_prev = 1'b0;
  int tdue = -1, fdue = -1, start_due = -1, wait_from = -1, out_rise = -1;
  int done_due = -1, err_due = -1, out_idx = 0, out_words = 0;
  int exp_tree = 0, exp_node = 0, exp_faddr = 0;
  logic [63:0] exp_tdata = '0, exp_fdata = '0, prev_data = '0;
  logic [LW-1:0] exp_burst = '0;
  int cnt_ldt = 0, cnt_ldf = 0, last_faddr = -1, cnt_start = 0, cnt_ow = 0;
  int cnt_last = 0, cnt_done = 0, cnt_err = 0;
  int w256_seen = 0, w256_tree = -1, w256_node = -1;

  task automatic monitor();
    bit out_on;
    int len;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        words_left = 0; busy_m = 1'b0; stall_prev = 1'b0;
        tdue = -1; fdue = -1; start_due = -1; wait_from = -1; out_rise = -1;
        done_due = -1; err_due = -1; exp_burst = '0;
        chk("rst_ctl", {cmd_ready, in_ready, out_valid, out_last, cmd_done, cmd_err,
                        busy, load_trees, load_features, start}, 64'b10_0000_0000);
        chk("rst_addr", {n_tree, n_node, feature_addr, burst_len, prediction_addr}, 64'd0);
        chk("rst_data", tree_nodes | features2 | out_data, 64'd0);
      end else begin
        out_on = (out_rise >= 0) && (cyc >= out_rise);
        chk("cmd_ready", cmd_ready, !busy_m);
        chk("busy", busy, busy_m);
        chk("in_ready", in_ready, words_left > 0);
        chk("load_trees", load_trees, tdue == cyc);
        if (tdue == cyc) begin
          chk("n_tree", n_tree, exp_tree);
          chk("n_node", n_node, exp_node);
          chk("tree_nodes", tree_nodes, exp_tdata);
        end
        chk("load_features", load_features, fdue == cyc);
        if (fdue == cyc) begin
          chk("feature_addr", feature_addr, exp_faddr);
          chk("features2", features2, exp_fdata);
        end
        chk("start", start, start_due == cyc);
        chk("cmd_done", cmd_done, done_due == cyc);
        chk("cmd_err", cmd_err, err_due == cyc);
        chk("out_valid", out_valid, out_on);
        if (out_on) begin
          chk("out_data", out_data, pred_fn(out_idx));
          chk("out_last", out_last, out_idx == out_words - 1);
        end
        if (stall_prev) chk("stall_stable", out_data, prev_data);
        chk("burst_len", burst_len, exp_burst);

        if (load_trees) begin
          cnt_ldt++;
          if (tree_nodes == 64'd256) begin
            w256_seen++; w256_tree = int'(n_tree); w256_node = int'(n_node);
          end
        end
        if (load_features) begin cnt_ldf++; last_faddr = int'(feature_addr); end
        if (start) cnt_start++;
        if (cmd_done) cnt_done++;
        if (cmd_err) cnt_err++;
        if (out_valid && out_ready) begin cnt_ow++; if (out_last) cnt_last++; end

        stall_prev = out_valid && !out_ready;
        prev_data = out_data;
        if (words_left > 0 && in_valid) begin
          if (!mode_feat) begin
            tdue = cyc + 1; exp_tree = k / N_NODE; exp_node = k % N_NODE; exp_tdata = in_data;
          end else begin
            fdue = cyc + 1; exp_faddr = k; exp_fdata = in_data;
          end
          k++;
          words_left--;
          if (words_left == 0) begin
            if (!mode_feat) begin done_due = cyc + 1; busy_m = 1'b0; end
            else begin start_due = cyc + 2; wait_from = cyc + 2; end
          end
        end else if (!busy_m && cmd_valid) begin
          len = int'(cmd_len);
          k = 0;
          if (!cmd_op) begin
            words_left = N_TREES * N_NODE; mode_feat = 1'b0; busy_m = 1'b1;
          end else if (len == 0) begin
            done_due = cyc + 1;
          end else if (len > MAXB) begin
            err_due = cyc + 1;
          end else begin
            words_left = len * N_FEAT / 2; mode_feat = 1'b1; busy_m = 1'b1;
            exp_burst = cmd_len; out_words = (len + 7) / 8;
          end
        end
        if (wait_from >= 0 && cyc >= wait_from && done) begin
          out_rise = cyc + 2; out_idx = 0; wait_from = -1;
        end
        if (out_on && out_ready) begin
          if (out_idx == out_words - 1) begin
            done_due = cyc + 1; busy_m = 1'b0; out_rise = -1;
          end else begin
            out_idx++; out_rise = cyc + 2;
          end
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  endtask

  task automatic send_cmd(input bit op, input int len);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic stream(input string name, input int n, input bit seq, input int gap_pct);
    int sent = 0;
    int budget = n * 4 + 200;
    bit acc = 1'b0;
    while (sent < n && budget > 0) begin
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      if (!in_valid && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data = seq ? 64'(sent) : {$urandom, $urandom};
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      budget--;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(name, sent, n);
  endtask

  task automatic wait_cmd_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = cmd_done;
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
  endtask

  int s_ldt, s_ldf, s_st, s_ow, s_ol, s_cd, s_ce;
  task automatic snap();
    s_ldt = cnt_ldt; s_ldf = cnt_ldf; s_st = cnt_start; s_ow = cnt_ow;
    s_ol = cnt_last; s_cd = cnt_done; s_ce = cnt_err;
  endtask

  int len;

  initial begin
    fork
      monitor();
      drive_ready();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // tree load with word value = k
    snap();
    send_cmd(1'b0, 0);
    stream("tree_words", N_TREES * N_NODE, 1'b1, 0);
    wait_cmd_done("tree_cmd_done", 20);
    chk("tree_w256_seen", w256_seen, 1);
    chk("tree_w256_ntree", w256_tree, 1);
    chk("tree_w256_nnode", w256_node, 0);
    chk("tree_writes", cnt_ldt - s_ldt, 4096);
    chk("tree_done_cnt", cnt_done - s_cd, 1);

    // spurious done while idle must be ignored
    pulse_done(2);
    repeat (3) @(posedge clk);

    // inference of 9 samples, extra input word offered afterwards
    snap();
    salt = $urandom;
    send_cmd(1'b1, 9);
    stream("inf9_words", 144, 1'b0, 25);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    pulse_done(45);
    wait_cmd_done("inf9_cmd_done", 100);
    chk("inf9_feat_writes", cnt_ldf - s_ldf, 144);
    chk("inf9_last_faddr", last_faddr, 143);
    chk("inf9_starts", cnt_start - s_st, 1);
    chk("inf9_out_words", cnt_ow - s_ow, 2);
    chk("inf9_out_last", cnt_last - s_ol, 1);

    // random length, random backpressure on the output
    for (int r = 0; r < 3; r++) begin
      snap();
      salt = $urandom;
      len = $urandom_range(60, 17);
      rdy_rand = 1'b1;
      send_cmd(1'b1, len);
      stream("bp_words", len * 16, 1'b0, 10);
      pulse_done($urandom_range(8, 1));
      wait_cmd_done("bp_cmd_done", 2000);
      chk("bp_out_words", cnt_ow - s_ow, (len + 7) / 8);
      rdy_rand = 1'b0;
    end

    // rejection cases
    snap();
    send_cmd(1'b1, 0);
    repeat (3) @(posedge clk);
    send_cmd(1'b1, MAXB + 1);
    repeat (4) @(posedge clk);
    chk("rej_done", cnt_done - s_cd, 1);
    chk("rej_err", cnt_err - s_ce, 1);
    chk("rej_starts", cnt_start - s_st, 0);
    chk("rej_loads", (cnt_ldf - s_ldf) + (cnt_ldt - s_ldt), 0);

    // reset in the middle of a feature load
    snap();
    send_cmd(1'b1, 4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_data = {$urandom, $urandom};
    end
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("rstmid_no_done", cnt_done - s_cd, 0);
    chk("rstmid_no_start", cnt_start - s_st, 0);

    // full burst
    snap();
    salt = $urandom;
    send_cmd(1'b1, MAXB);
    stream("full_words", MAXB * N_FEAT / 2, 1'b0, 0);
    pulse_done(3);
    wait_cmd_done("full_cmd_done", 2000);
    chk("full_last_faddr", last_faddr, 79999);
    chk("full_out_words", cnt_ow - s_ow, 625);
    chk("full_starts", cnt_start - s_st, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
